// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that shares the TX FIFO write port among the ALU,
// RegFile and status byte producers, streaming each granted frame byte by byte.
module tx_fifo_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ALU_REQ,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  input  logic                    ALU_TWO_B,
  output logic                    ALU_ACK,
  input  logic                    RF_REQ,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  output logic                    RF_ACK,
  input  logic                    ST_REQ,
  input  logic [DATA_WIDTH-1:0]   ST_DATA,
  output logic                    ST_ACK,
  input  logic                    FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  output logic                    ARB_BUSY
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_e;
  typedef enum logic [1:0] {SRC_ALU, SRC_RF, SRC_ST} src_e;

  state_e                state_q, state_d;
  src_e                  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  two_b_q, two_b_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  alu_ack_q, alu_ack_d;
  logic                  rf_ack_q, rf_ack_d;
  logic                  st_ack_q, st_ack_d;

  logic                  gnt_valid;
  src_e                  gnt_src;

  // Pick the first active requester at or after the round-robin pointer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_ALU;
    unique case (rr_q)
      SRC_ALU: begin
        if (ALU_REQ)     begin gnt_valid = 1'b1; gnt_src = SRC_ALU; end
        else if (RF_REQ) begin gnt_valid = 1'b1; gnt_src = SRC_RF;  end
        else if (ST_REQ) begin gnt_valid = 1'b1; gnt_src = SRC_ST;  end
      end
      SRC_RF: begin
        if (RF_REQ)       begin gnt_valid = 1'b1; gnt_src = SRC_RF;  end
        else if (ST_REQ)  begin gnt_valid = 1'b1; gnt_src = SRC_ST;  end
        else if (ALU_REQ) begin gnt_valid = 1'b1; gnt_src = SRC_ALU; end
      end
      default: begin
        if (ST_REQ)       begin gnt_valid = 1'b1; gnt_src = SRC_ST;  end
        else if (ALU_REQ) begin gnt_valid = 1'b1; gnt_src = SRC_ALU; end
        else if (RF_REQ)  begin gnt_valid = 1'b1; gnt_src = SRC_RF;  end
      end
    endcase
  end

  // Next-state logic: grant and latch in IDLE, then stream bytes, stalling on FULL.
  // The low byte goes straight into the output register at grant time, so only
  // the high byte needs its own frame register.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hi_d      = hi_q;
    two_b_d   = two_b_q;
    wr_data_d = wr_data_q;
    alu_ack_d = 1'b0;
    rf_ack_d  = 1'b0;
    st_ack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SEND_LO;
          unique case (gnt_src)
            SRC_ALU: begin
              wr_data_d = ALU_DATA[DATA_WIDTH-1:0];
              hi_d      = ALU_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
              two_b_d   = ALU_TWO_B;
              alu_ack_d = 1'b1;
              rr_d      = SRC_RF;
            end
            SRC_RF: begin
              wr_data_d = RF_DATA;
              hi_d      = '0;
              two_b_d   = 1'b0;
              rf_ack_d  = 1'b1;
              rr_d      = SRC_ST;
            end
            default: begin
              wr_data_d = ST_DATA;
              hi_d      = '0;
              two_b_d   = 1'b0;
              st_ack_d  = 1'b1;
              rr_d      = SRC_ALU;
            end
          endcase
        end
      end
      SEND_LO: begin
        if (!FIFO_FULL) begin
          if (two_b_q) begin
            state_d   = SEND_HI;
            wr_data_d = hi_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SEND_HI: begin
        if (!FIFO_FULL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and frame registers; reset discards any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      rr_q      <= SRC_ALU;
      hi_q      <= '0;
      two_b_q   <= 1'b0;
      wr_data_q <= '0;
      alu_ack_q <= 1'b0;
      rf_ack_q  <= 1'b0;
      st_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      hi_q      <= hi_d;
      two_b_q   <= two_b_d;
      wr_data_q <= wr_data_d;
      alu_ack_q <= alu_ack_d;
      rf_ack_q  <= rf_ack_d;
      st_ack_q  <= st_ack_d;
    end
  end

  assign ALU_ACK      = alu_ack_q;
  assign RF_ACK       = rf_ack_q;
  assign ST_ACK       = st_ack_q;
  assign FIFO_WR_DATA = wr_data_q;
  assign ARB_BUSY     = (state_q != IDLE);
  // Write strobe is combinational on FULL so a write is never issued while full.
  assign FIFO_WR_INC  = (state_q != IDLE) && !FIFO_FULL;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter with hand-computed expectations.
module tb_tx_fifo_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_REQ, ALU_TWO_B, RF_REQ, ST_REQ, FIFO_FULL;
  logic [15:0] ALU_DATA;
  logic [7:0]  RF_DATA, ST_DATA;
  logic        ALU_ACK, RF_ACK, ST_ACK, FIFO_WR_INC, ARB_BUSY;
  logic [7:0]  FIFO_WR_DATA;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  wlog[$];

  tx_fifo_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_REQ(ALU_REQ), .ALU_DATA(ALU_DATA), .ALU_TWO_B(ALU_TWO_B), .ALU_ACK(ALU_ACK),
    .RF_REQ(RF_REQ), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
    .ST_REQ(ST_REQ), .ST_DATA(ST_DATA), .ST_ACK(ST_ACK),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_INC(FIFO_WR_INC), .ARB_BUSY(ARB_BUSY)
  );

  always #5 CLK = ~CLK;

  // Record every byte the FIFO actually accepts.
  always @(posedge CLK) if (FIFO_WR_INC === 1'b1) wlog.push_back(FIFO_WR_DATA);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks acks {ALU,RF,ST}, busy, inc and data at once.
  task automatic chk_out(input string tag, input logic [2:0] acks, input logic busy,
                         input logic inc, input logic [7:0] data);
    chk({tag, "_acks"}, {13'd0, ALU_ACK, RF_ACK, ST_ACK}, {13'd0, acks});
    chk({tag, "_busy"}, {15'd0, ARB_BUSY}, {15'd0, busy});
    chk({tag, "_inc"},  {15'd0, FIFO_WR_INC}, {15'd0, inc});
    chk({tag, "_data"}, {8'd0, FIFO_WR_DATA}, {8'd0, data});
  endtask

  initial begin
    RST = 1'b0; ALU_REQ = 1'b0; ALU_TWO_B = 1'b0; RF_REQ = 1'b0; ST_REQ = 1'b0;
    FIFO_FULL = 1'b0; ALU_DATA = '0; RF_DATA = '0; ST_DATA = '0;
    #12;
    chk_out("reset", 3'b000, 1'b0, 1'b0, 8'h00);
    RST = 1'b1;
    tick();
    chk_out("idle", 3'b000, 1'b0, 1'b0, 8'h00);

    // Two-byte ALU frame
    ALU_REQ = 1'b1; ALU_DATA = 16'hA55A; ALU_TWO_B = 1'b1;
    tick();
    ALU_REQ = 1'b0;
    chk_out("alu2_lo", 3'b100, 1'b1, 1'b1, 8'h5A);
    tick();
    chk_out("alu2_hi", 3'b000, 1'b1, 1'b1, 8'hA5);
    tick();
    chk_out("alu2_end", 3'b000, 1'b0, 1'b0, 8'hA5);

    // All three request together straight out of reset
    RST = 1'b0; #2; RST = 1'b1;
    wlog.delete();
    ALU_REQ = 1'b1; ALU_DATA = 16'hBEEF; ALU_TWO_B = 1'b1;
    RF_REQ = 1'b1; RF_DATA = 8'h77; ST_REQ = 1'b1; ST_DATA = 8'h99;
    tick();
    ALU_REQ = 1'b0;
    chk_out("rr_alu_lo", 3'b100, 1'b1, 1'b1, 8'hEF);
    tick();
    chk_out("rr_alu_hi", 3'b000, 1'b1, 1'b1, 8'hBE);
    tick();
    chk_out("rr_gap1", 3'b000, 1'b0, 1'b0, 8'hBE);
    tick();
    RF_REQ = 1'b0;
    chk_out("rr_rf", 3'b010, 1'b1, 1'b1, 8'h77);
    tick();
    chk_out("rr_gap2", 3'b000, 1'b0, 1'b0, 8'h77);
    tick();
    ST_REQ = 1'b0;
    chk_out("rr_st", 3'b001, 1'b1, 1'b1, 8'h99);
    tick();
    chk("rr_wlog_n", 16'(wlog.size()), 16'd4);
    chk("rr_wlog", {wlog[0], wlog[1]}, 16'hEFBE);
    chk("rr_wlog2", {wlog[2], wlog[3]}, 16'h7799);

    // RegFile byte stalled by FIFO full for 5 cycles (pointer now at ALU)
    wlog.delete();
    RF_REQ = 1'b1; RF_DATA = 8'h3C; FIFO_FULL = 1'b1;
    tick();
    RF_REQ = 1'b0;
    chk("full_ack", {15'd0, RF_ACK}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("full_stall%0d", i), (i == 0) ? 3'b010 : 3'b000, 1'b1, 1'b0, 8'h3C);
      if (i < 4) tick();
    end
    FIFO_FULL = 1'b0;
    #1;
    chk_out("full_release", 3'b000, 1'b1, 1'b1, 8'h3C);
    tick();
    chk_out("full_end", 3'b000, 1'b0, 1'b0, 8'h3C);
    chk("full_wlog_n", 16'(wlog.size()), 16'd1);
    chk("full_wlog", {8'd0, wlog[0]}, 16'h003C);

    // ALU held continuously alongside ST (pointer now at ST)
    ALU_REQ = 1'b1; ALU_DATA = 16'h00C3; ALU_TWO_B = 1'b0;
    ST_REQ = 1'b1; ST_DATA = 8'h5E;
    tick();
    chk_out("fair_st1", 3'b001, 1'b1, 1'b1, 8'h5E);
    tick();
    tick();
    chk_out("fair_alu1", 3'b100, 1'b1, 1'b1, 8'hC3);
    tick();
    tick();
    chk_out("fair_st2", 3'b001, 1'b1, 1'b1, 8'h5E);
    tick();
    tick();
    ALU_REQ = 1'b0; ST_REQ = 1'b0;
    chk_out("fair_alu2", 3'b100, 1'b1, 1'b1, 8'hC3);
    tick();
    chk_out("fair_end", 3'b000, 1'b0, 1'b0, 8'hC3);

    // FULL raised between the low and high byte
    wlog.delete();
    ALU_REQ = 1'b1; ALU_DATA = 16'h1234; ALU_TWO_B = 1'b1;
    tick();
    ALU_REQ = 1'b0;
    chk_out("tog_lo", 3'b100, 1'b1, 1'b1, 8'h34);
    tick();
    FIFO_FULL = 1'b1;
    #1;
    chk_out("tog_hi_full", 3'b000, 1'b1, 1'b0, 8'h12);
    tick();
    chk_out("tog_hi_full2", 3'b000, 1'b1, 1'b0, 8'h12);
    FIFO_FULL = 1'b0;
    #1;
    chk_out("tog_hi_go", 3'b000, 1'b1, 1'b1, 8'h12);
    tick();
    chk_out("tog_end", 3'b000, 1'b0, 1'b0, 8'h12);
    chk("tog_wlog_n", 16'(wlog.size()), 16'd2);
    chk("tog_wlog", {wlog[0], wlog[1]}, 16'h3412);

    // Reset in the middle of a stalled high byte, then a clean restart
    ALU_REQ = 1'b1; ALU_DATA = 16'hDEAD; ALU_TWO_B = 1'b1;
    tick();
    ALU_REQ = 1'b0;
    tick();
    FIFO_FULL = 1'b1;
    #1;
    chk_out("mid_hi", 3'b000, 1'b1, 1'b0, 8'hDE);
    RST = 1'b0;
    #1;
    chk_out("mid_reset", 3'b000, 1'b0, 1'b0, 8'h00);
    #1;
    RST = 1'b1; FIFO_FULL = 1'b0;
    // Pointer was at RF before reset; the ALU grant shows it went back to ALU.
    ALU_REQ = 1'b1; ALU_DATA = 16'h00F0; ALU_TWO_B = 1'b0; RF_REQ = 1'b1; RF_DATA = 8'h11;
    tick();
    ALU_REQ = 1'b0;
    chk_out("restart", 3'b100, 1'b1, 1'b1, 8'hF0);
    tick();
    chk_out("restart_end", 3'b000, 1'b0, 1'b0, 8'hF0);
    tick();
    RF_REQ = 1'b0;
    chk_out("restart_rf", 3'b010, 1'b1, 1'b1, 8'h11);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
